// File: rtl/lisnoc_dist_rr_pkg.sv
// Shared definitions for the packet-granular round-robin distributor.
//   - flit type encodings (carried in the MSBs of a flit)
//   - default flit widths
//   - distributor state encoding
package lisnoc_dist_rr_pkg;

  localparam int LISNOC_FLIT_DATA_WIDTH_DEF = 32;
  localparam int LISNOC_FLIT_TYPE_WIDTH_DEF = 2;

  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEAD    = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } dist_state_t;

endpackage

// File: rtl/lisnoc_dist_rr_sel.sv
// Circular first-one finder used to pick the next output for a new packet.
// The scan starts at the position just after the one-hot last grant and
// wraps from N-1 back to 0, so the most recently used output gets the
// lowest priority.
// Ports:
//   ready    in  N  per-output ready
//   last_gnt in  N  one-hot previous grant
//   cand     out N  one-hot candidate (zero when nothing is ready)
//   found    out 1  a candidate exists
module lisnoc_dist_rr_sel #(
  parameter int N = 2
) (
  input  logic [N-1:0] ready,
  input  logic [N-1:0] last_gnt,
  output logic [N-1:0] cand,
  output logic         found
);

  int last_idx;
  int idx;

  always_comb begin
    last_idx = N - 1;
    for (int i = 0; i < N; i++) begin
      if (last_gnt[i]) last_idx = i;
    end
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int o = 1; o <= N; o++) begin
      idx = (last_idx + o) % N;
      if (!found && ready[idx]) begin
        cand[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lisnoc_dist_rr.sv
// Packet-granular round-robin distributor: one flit stream in, whole packets
// spread over N outputs. A single registered flit stage sits in front of all
// outputs; the output the register belongs to is 'sel'.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_flit    input flit (type in MSBs), in_valid / in_ready handshake
//   out_flit   N copies of the registered flit
//   out_valid  one-hot (or zero) valid for the locked output
//   out_ready  per-output ready
//   err        (only with LISNOC_DIST_RR_ERRCHK_EN) sticky protocol error
// Optional feature macro: LISNOC_DIST_RR_ERRCHK_EN
module lisnoc_dist_rr
  import lisnoc_dist_rr_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = LISNOC_FLIT_DATA_WIDTH_DEF,
  parameter int FLIT_TYPE_WIDTH = LISNOC_FLIT_TYPE_WIDTH_DEF,
  parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  parameter int N               = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH-1:0]   in_flit,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N*FLIT_WIDTH-1:0] out_flit,
  output logic [N-1:0]            out_valid,
  input  logic [N-1:0]            out_ready
`ifdef LISNOC_DIST_RR_ERRCHK_EN
  ,
  output logic                    err
`endif
);

  dist_state_t state, state_nxt;

  logic [FLIT_WIDTH-1:0]      flit_p0;
  logic                       vld_p0;
  // sel is both the lock for the current packet and the last grant for the
  // next round-robin scan: it only changes when a new flit is loaded.
  logic [N-1:0]               sel;

  logic [FLIT_TYPE_WIDTH-1:0] typ;
  logic                       is_head;
  logic                       is_last;
  logic                       drain;
  logic                       free;
  logic [N-1:0]               cand;
  logic                       found;
  logic                       load;
  logic [N-1:0]               load_sel;
`ifdef LISNOC_DIST_RR_ERRCHK_EN
  logic                       set_err;
  logic                       err_p0;
`endif

  assign typ     = in_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
  assign is_head = (typ == FLIT_TYPE_WIDTH'(FLIT_TYPE_HEAD)) ||
                   (typ == FLIT_TYPE_WIDTH'(FLIT_TYPE_SINGLE));
  assign is_last = (typ == FLIT_TYPE_WIDTH'(FLIT_TYPE_LAST));

  // The register is reusable this cycle if empty or leaving right now.
  assign drain = vld_p0 & |(sel & out_ready);
  assign free  = ~vld_p0 | drain;

  lisnoc_dist_rr_sel #(.N(N)) u_sel (
    .ready    (out_ready),
    .last_gnt (sel),
    .cand     (cand),
    .found    (found)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    load_sel  = sel;
`ifdef LISNOC_DIST_RR_ERRCHK_EN
    set_err   = 1'b0;
`endif
    if (!rst) begin
      case (state)
        IDLE: begin
          if (is_head) begin
            in_ready = free & found;
            if (in_valid && in_ready) begin
              load     = 1'b1;
              load_sel = cand;
              if (!is_last && typ == FLIT_TYPE_WIDTH'(FLIT_TYPE_HEAD))
                state_nxt = ACTIVE;
            end
          end else begin
`ifdef LISNOC_DIST_RR_ERRCHK_EN
            // Stray body flit: swallow it and flag the violation.
            in_ready = 1'b1;
            set_err  = in_valid;
`else
            // Stray body flit: follow the previous grant.
            in_ready = free;
            load     = in_valid;
`endif
          end
        end
        ACTIVE: begin
          in_ready = free;
          if (in_valid && in_ready) begin
            load = 1'b1;
            if (is_last) state_nxt = IDLE;
`ifdef LISNOC_DIST_RR_ERRCHK_EN
            set_err = is_head;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: registered flit shared by all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      flit_p0 <= '0;
      sel     <= N'(1) << (N - 1);
    end else if (load) begin
      vld_p0  <= 1'b1;
      flit_p0 <= in_flit;
      sel     <= load_sel;
    end else if (drain) begin
      vld_p0  <= 1'b0;
    end
  end

`ifdef LISNOC_DIST_RR_ERRCHK_EN
  always_ff @(posedge clk) begin
    if (rst)          err_p0 <= 1'b0;
    else if (set_err) err_p0 <= 1'b1;
  end
  assign err = err_p0;
`endif

  assign out_valid = vld_p0 ? sel : '0;
  assign out_flit  = {N{flit_p0}};

endmodule

// File: tb/tb_lisnoc_dist_rr.sv
// Directed bench for lisnoc_dist_rr: a vector table on an N=4 instance plus
// short hand-written sequences (N=3 wrap/skip, stray-flit handling).
module tb_lisnoc_dist_rr;

  localparam int DW = 32;
  localparam int FW = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic          rst4;
  logic [FW-1:0] in_flit4;
  logic          in_valid4;
  logic          in_ready4;
  logic [4*FW-1:0] out_flit4;
  logic [3:0]    out_valid4;
  logic [3:0]    out_ready4;
  // N=3 instance
  logic          rst3;
  logic [FW-1:0] in_flit3;
  logic          in_valid3;
  logic          in_ready3;
  logic [3*FW-1:0] out_flit3;
  logic [2:0]    out_valid3;
  logic [2:0]    out_ready3;
`ifdef LISNOC_DIST_RR_ERRCHK_EN
  logic          err4;
  logic          err3;
`endif

  lisnoc_dist_rr #(.FLIT_DATA_WIDTH(DW), .FLIT_TYPE_WIDTH(2), .N(4)) dut4 (
    .clk       (clk),
    .rst       (rst4),
    .in_flit   (in_flit4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_flit  (out_flit4),
    .out_valid (out_valid4),
    .out_ready (out_ready4)
`ifdef LISNOC_DIST_RR_ERRCHK_EN
    ,
    .err       (err4)
`endif
  );

  lisnoc_dist_rr #(.FLIT_DATA_WIDTH(DW), .FLIT_TYPE_WIDTH(2), .N(3)) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .in_flit   (in_flit3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_flit  (out_flit3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef LISNOC_DIST_RR_ERRCHK_EN
    ,
    .err       (err3)
`endif
  );

  localparam logic [1:0] PL = 2'b00, HD = 2'b01, LS = 2'b10, SG = 2'b11;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [1:0]    typ;
    logic [DW-1:0] dat;
    logic [3:0]    rdy;
    logic          exp_ir;
    logic [3:0]    exp_ov;
    logic          cf;
    logic [FW-1:0] exp_flit;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [DW-1:0] d);
    return {t, d};
  endfunction

  task automatic add(input logic r, input logic v, input logic [1:0] t,
                     input logic [DW-1:0] d, input logic [3:0] rdy,
                     input logic ir, input logic [3:0] ov,
                     input logic cf, input logic [FW-1:0] ef);
    vec_t e;
    e.rst = r; e.vld = v; e.typ = t; e.dat = d; e.rdy = rdy;
    e.exp_ir = ir; e.exp_ov = ov; e.cf = cf; e.exp_flit = ef;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [4*FW-1:0] act,
                     input logic [4*FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // reset check
    add(1, 0, SG, 32'h0,  4'b1111, 0, 4'b0000, 1, '0);
    // four SINGLEs, all ready: outputs 0,1,2,3 back to back
    add(0, 1, SG, 32'hA0, 4'b1111, 1, 4'b0000, 0, '0);
    add(0, 1, SG, 32'hA1, 4'b1111, 1, 4'b0001, 1, mk(SG, 32'hA0));
    add(0, 1, SG, 32'hA2, 4'b1111, 1, 4'b0010, 1, mk(SG, 32'hA1));
    add(0, 1, SG, 32'hA3, 4'b1111, 1, 4'b0100, 1, mk(SG, 32'hA2));
    add(0, 0, SG, 32'h0,  4'b1111, 1, 4'b1000, 1, mk(SG, 32'hA3));
    add(0, 0, SG, 32'h0,  4'b1111, 1, 4'b0000, 0, '0);
    // 5-flit packet locked to output 0 while its ready toggles
    add(0, 1, HD, 32'hB0, 4'b1111, 1, 4'b0000, 0, '0);
    add(0, 1, PL, 32'hB1, 4'b1110, 0, 4'b0001, 1, mk(HD, 32'hB0));
    add(0, 1, PL, 32'hB1, 4'b1111, 1, 4'b0001, 1, mk(HD, 32'hB0));
    add(0, 1, PL, 32'hB2, 4'b1111, 1, 4'b0001, 1, mk(PL, 32'hB1));
    add(0, 1, PL, 32'hB3, 4'b1110, 0, 4'b0001, 1, mk(PL, 32'hB2));
    add(0, 1, PL, 32'hB3, 4'b1111, 1, 4'b0001, 1, mk(PL, 32'hB2));
    add(0, 1, LS, 32'hB4, 4'b1111, 1, 4'b0001, 1, mk(PL, 32'hB3));
    add(0, 0, SG, 32'h0,  4'b1111, 1, 4'b0001, 1, mk(LS, 32'hB4));
    add(0, 0, SG, 32'h0,  4'b1111, 1, 4'b0000, 0, '0);
    // nothing ready: HEAD held off for 10 cycles, then output 1 opens
    for (int i = 0; i < 10; i++)
      add(0, 1, HD, 32'hC0, 4'b0000, 0, 4'b0000, 0, '0);
    add(0, 1, HD, 32'hC0, 4'b0010, 1, 4'b0000, 0, '0);
    add(0, 1, LS, 32'hC1, 4'b0010, 1, 4'b0010, 1, mk(HD, 32'hC0));
    add(0, 0, SG, 32'h0,  4'b0010, 1, 4'b0010, 1, mk(LS, 32'hC1));
    add(0, 0, SG, 32'h0,  4'b1111, 1, 4'b0000, 0, '0);
    // reset mid-packet
    add(0, 1, HD, 32'hD0, 4'b1111, 1, 4'b0000, 0, '0);
    add(0, 1, PL, 32'hD1, 4'b1111, 1, 4'b0100, 1, mk(HD, 32'hD0));
    add(1, 0, SG, 32'h0,  4'b1111, 0, 4'b0100, 1, mk(PL, 32'hD1));
    add(0, 1, SG, 32'hD2, 4'b1111, 1, 4'b0000, 1, '0);
    add(0, 0, SG, 32'h0,  4'b1111, 1, 4'b0001, 1, mk(SG, 32'hD2));
    add(0, 0, SG, 32'h0,  4'b1111, 1, 4'b0000, 0, '0);

    rst4 = 1'b1; in_valid4 = 1'b0; in_flit4 = '0; out_ready4 = '0;
    rst3 = 1'b1; in_valid3 = 1'b0; in_flit3 = '0; out_ready3 = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst4       = vecs[i].rst;
      in_valid4  = vecs[i].vld;
      in_flit4   = mk(vecs[i].typ, vecs[i].dat);
      out_ready4 = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d in_ready", i), {135'd0, in_ready4}, {135'd0, vecs[i].exp_ir});
      chk($sformatf("v%0d out_valid", i), {132'd0, out_valid4}, {132'd0, vecs[i].exp_ov});
      if (vecs[i].cf)
        chk($sformatf("v%0d out_flit", i), out_flit4, {4{vecs[i].exp_flit}});
    end

`ifdef LISNOC_DIST_RR_ERRCHK_EN
    // stray PAYLOAD in IDLE: swallowed, err sticks until reset
    @(negedge clk);
    in_valid4 = 1'b1; in_flit4 = mk(PL, 32'hE0); out_ready4 = 4'b0000;
    #1;
    chk("stray in_ready", {135'd0, in_ready4}, {135'd0, 1'b1});
    chk("err before", {135'd0, err4}, '0);
    @(negedge clk);
    in_valid4 = 1'b0; in_flit4 = mk(SG, 32'h0);
    #1;
    chk("stray not forwarded", {132'd0, out_valid4}, '0);
    chk("err set", {135'd0, err4}, {135'd0, 1'b1});
    repeat (3) @(negedge clk);
    #1;
    chk("err sticky", {135'd0, err4}, {135'd0, 1'b1});
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("err cleared", {135'd0, err4}, '0);
`else
    // stray PAYLOAD in IDLE: forwarded to the last grant (output 0)
    @(negedge clk);
    in_valid4 = 1'b1; in_flit4 = mk(PL, 32'hE0); out_ready4 = 4'b0000;
    #1;
    chk("stray in_ready", {135'd0, in_ready4}, {135'd0, 1'b1});
    @(negedge clk);
    in_valid4 = 1'b0; in_flit4 = mk(SG, 32'h0);
    #1;
    chk("stray out_valid", {132'd0, out_valid4}, {132'd0, 4'b0001});
    chk("stray out_flit", out_flit4, {4{mk(PL, 32'hE0)}});
    chk("stray blocks head", {135'd0, in_ready4}, '0);
`endif

    // N=3: skip a never-ready output, then wrap back to output 0
    @(negedge clk);
    rst3 = 1'b0;
    in_valid3 = 1'b1; in_flit3 = mk(SG, 32'hF0); out_ready3 = 3'b111;
    #1;
    chk("n3 s0 in_ready", {135'd0, in_ready3}, {135'd0, 1'b1});
    @(negedge clk);
    in_flit3 = mk(HD, 32'hF1); out_ready3 = 3'b101;
    #1;
    chk("n3 s0 out_valid", {133'd0, out_valid3}, {133'd0, 3'b001});
    chk("n3 head in_ready", {135'd0, in_ready3}, {135'd0, 1'b1});
    @(negedge clk);
    in_flit3 = mk(LS, 32'hF2);
    #1;
    chk("n3 head skip to 2", {133'd0, out_valid3}, {133'd0, 3'b100});
    chk("n3 head flit", {34'd0, out_flit3}, {34'd0, {3{mk(HD, 32'hF1)}}});
    @(negedge clk);
    in_flit3 = mk(SG, 32'hF3); out_ready3 = 3'b111;
    #1;
    chk("n3 last out_valid", {133'd0, out_valid3}, {133'd0, 3'b100});
    chk("n3 wrap in_ready", {135'd0, in_ready3}, {135'd0, 1'b1});
    @(negedge clk);
    in_valid3 = 1'b0;
    #1;
    chk("n3 wrap to 0", {133'd0, out_valid3}, {133'd0, 3'b001});
    chk("n3 wrap flit", {34'd0, out_flit3}, {34'd0, {3{mk(SG, 32'hF3)}}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lisnoc_dist_rr.md
Name: lisnoc_dist_rr

Overview:
- Packet-granular round-robin distributor. It is the fan-out counterpart to the NoC's round-robin arbiters.
- Takes one flit stream and spreads whole packets over N output channels, for example to parallel NI queues or virtual channels.
- Holds one registered flit stage. Stays locked to the chosen output until the packet's LAST flit has been accepted.

Parameters:
- FLIT_DATA_WIDTH, 32, payload bits per flit.
- FLIT_TYPE_WIDTH, 2, flit type bits.
- FLIT_WIDTH, FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH, total flit width, derived.
- N, 2, number of output channels (N >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  FLIT_WIDTH  input flit; type is in the MSBs.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input flit accepted when in_valid & in_ready.
- out_flit  out  N*FLIT_WIDTH  per-output flit; all slices carry the same registered flit.
- out_valid  out  N  one-hot or zero; set only for the locked output.
- out_ready  in  N  per-output ready.
- Reset is synchronous and active-high on rst; single clock clk.

Behaviour:
- Flit types: HEAD=2'b01, PAYLOAD=2'b00, LAST=2'b10, SINGLE=2'b11.
- Output stage:
  - One flit register plus reg_valid.
  - out_valid = reg_valid ? sel : 0.
  - Transfer on an output when out_valid[k] & out_ready[k].
  - in_ready = ~reg_valid | out_ready[sel_k], gated further by selection (below).
  - Latency is 1 cycle from input acceptance to out_valid.
  - Full throughput of 1 flit/cycle when the selected output is continuously ready.
- State machine: IDLE and ACTIVE.
  - IDLE, HEAD or SINGLE presented:
    - Candidate = first k with out_ready[k]=1, scanning circularly from last_gnt+1.
    - If a candidate exists: accept the flit, set sel=onehot(candidate), last_gnt=candidate. A HEAD moves to ACTIVE; a SINGLE stays in IDLE.
    - If no candidate exists: in_ready=0 and no state change.
    - The scan uses out_ready in the same cycle, so selection is combinational on out_ready. reg_valid must be 0, or draining this cycle, before a new head is accepted.
  - ACTIVE:
    - PAYLOAD and LAST flits are forwarded to sel regardless of other outputs' ready.
    - Acceptance of LAST returns to IDLE.
    - sel holds until the registered LAST has drained. A new head may be accepted in the same cycle the LAST drains.
- Reset values:
  - reg_valid=0, out_valid=0, in_ready=0 during reset.
  - state=IDLE, last_gnt=N-1, so the first packet prefers output 0.
  - out_flit=0.
- Boundaries:
  - Pointer wrap: after output N-1 the scan continues from output 0.
  - Output k never ready: it is skipped and other outputs are still served, so there is no starvation of the stream.
  - Simultaneous drain and accept: the register is overwritten with the new flit in the same cycle; no bubble.
  - Reset mid-packet: the packet is abandoned and the register is cleared; the upstream must also reset.
  - Without the error-check macro, protocol violations are handled as follows:
    - PAYLOAD or LAST in IDLE is forwarded to last_gnt. Such a flit is accepted when the register is free or that output is ready.
    - HEAD or SINGLE in ACTIVE is treated as PAYLOAD.

Optional Feature:
- Macro: LISNOC_DIST_RR_ERRCHK_EN.
- When defined:
  - Adds port err (out, 1), a sticky flag cleared only by rst.
  - Stray PAYLOAD/LAST in IDLE are accepted (in_ready=1), dropped, and set err.
  - HEAD/SINGLE in ACTIVE sets err and is forwarded as PAYLOAD.
- When undefined: no err port and the behaviour described above.

Decomposition:
- Shared package holds:
  - Flit type constants: FLIT_TYPE_HEAD, FLIT_TYPE_PAYLOAD, FLIT_TYPE_LAST, FLIT_TYPE_SINGLE.
  - Default widths.
  - State encoding localparams: IDLE, ACTIVE.
- One natural sub-module: lisnoc_dist_rr_sel.
  - Combinational circular first-one finder over out_ready, starting after one-hot last_gnt.
  - Outputs a one-hot candidate and a found flag.

Test Plan:
- N=4, all out_ready=1, four SINGLE flits back-to-back → outputs 0,1,2,3 in order, one per cycle, each 1 cycle after acceptance.
- N=4, HEAD, 3xPAYLOAD, LAST to output 0 while out_ready[0] toggles 1,0,1 → all 5 flits appear only on output 0, in order; no flit on other outputs; in_ready low while stalled.
- N=3, last_gnt=0, out_ready=3'b101, HEAD presented → selects output 2 (output 1 skipped); the next SINGLE with all ready goes to output 0 (wrap).
- out_ready=0 on all outputs, HEAD presented → in_ready=0 for 10 cycles, no out_valid. out_ready[1]=1 → accepted, out_valid=4'b0010 the next cycle.
- rst asserted after HEAD+PAYLOAD forwarded → out_valid=0 next cycle; the next SINGLE goes to output 0.
- With LISNOC_DIST_RR_ERRCHK_EN: PAYLOAD in IDLE → accepted, not forwarded, err=1 and stays 1 until rst.
